// File: rtl/regfile_access_ctrl_pkg.sv
// Shared encodings and default sizes for the register-file access controller.
// The command opcode is an enum; FSM states are plain localparams so they match legacy encodings.
package regfile_access_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 4;
  localparam int NREGS_DEF  = 4;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_WVERIFY = 2'b10,
    OP_CLEAR   = 2'b11
  } op_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_CLR  = 3'd3;
  localparam logic [2:0] ST_SCAN = 3'd4;
  localparam logic [2:0] ST_RESP = 3'd5;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Command controller for the register-file port: READ, WRITE, WRITE_VERIFY and CLEAR
// with a zero-check scan, one held response per accepted command.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SEL_W  = SEL_W_DEF,
  parameter int NREGS  = NREGS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              rf_enable,
  output logic              rf_reset,
  output logic [SEL_W-1:0]  rf_sel,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  logic [2:0]        state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  op_e               op_q, op_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              sel_illegal;
  logic              scan_last;
  logic [DATA_W-1:0] scan_or;

  // One extra bit so NREGS == 2**SEL_W does not wrap to zero.
  assign sel_illegal = {1'b0, cmd_sel} >= (SEL_W + 1)'(NREGS);
  assign scan_last   = idx_q == SEL_W'(NREGS - 1);
  assign scan_or     = rsp_data_q | rf_rdata;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    sel_d      = sel_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          sel_d  = cmd_sel;
          data_d = cmd_data;
          if (op_e'(cmd_op) != OP_CLEAR && sel_illegal) begin
            state_d    = ST_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else begin
            case (op_e'(cmd_op))
              OP_READ:    state_d = ST_RD;
              OP_WRITE:   state_d = ST_WR;
              OP_WVERIFY: state_d = ST_WR;
              default:    state_d = ST_CLR;
            endcase
          end
        end
      end
      ST_RD: begin
        rsp_data_d = rf_rdata;
        rsp_err_d  = (op_q == OP_WVERIFY) && (rf_rdata != data_q);
        state_d    = ST_RESP;
      end
      ST_WR: begin
        if (op_q == OP_WVERIFY) begin
          state_d = ST_RD;
        end else begin
          rsp_data_d = data_q;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_CLR: begin
        idx_d      = '0;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        state_d    = ST_SCAN;
      end
      ST_SCAN: begin
        rsp_data_d = scan_or;
        if (scan_last) begin
          rsp_err_d = |scan_or;
          idx_d     = '0;
          state_d   = ST_RESP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read cycles write back what they read, so the register file sees a harmless refresh.
  always_comb begin
    rf_enable = 1'b0;
    rf_reset  = 1'b0;
    rf_sel    = '0;
    rf_wdata  = '0;
    case (state_q)
      ST_RD: begin
        rf_enable = 1'b1;
        rf_sel    = sel_q;
        rf_wdata  = rf_rdata;
      end
      ST_WR: begin
        rf_enable = 1'b1;
        rf_sel    = sel_q;
        rf_wdata  = data_q;
      end
      ST_CLR: begin
        rf_enable = 1'b1;
        rf_reset  = 1'b1;
      end
      ST_SCAN: begin
        rf_enable = 1'b1;
        rf_sel    = idx_q;
        rf_wdata  = rf_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      op_q       <= OP_READ;
      sel_q      <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign busy      = state_q != ST_IDLE;
  assign rsp_valid = state_q == ST_RESP;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register file and a response scoreboard.
module tb_regfile_access_ctrl;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 4;
  localparam int NREGS  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SEL_W-1:0]  cmd_sel;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              rf_enable;
  logic              rf_reset;
  logic [SEL_W-1:0]  rf_sel;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;

  regfile_access_ctrl #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .rf_enable(rf_enable), .rf_reset(rf_reset), .rf_sel(rf_sel),
    .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  // Register file model plus a log of every enabled cycle.
  typedef struct packed {
    logic              rst;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
  } rf_ev_t;

  logic [DATA_W-1:0] regs [NREGS];
  logic              force_b0;
  rf_ev_t            rf_log [$];

  assign rf_rdata = ((rf_sel < SEL_W'(NREGS)) ? regs[rf_sel[1:0]] : '0) | {{(DATA_W-1){1'b0}}, force_b0};

  always @(posedge clk) begin
    if (rf_enable) begin
      rf_log.push_back('{rst: rf_reset, sel: rf_sel, wdata: rf_wdata});
      if (rf_reset) begin
        for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else if (rf_sel < SEL_W'(NREGS)) begin
        regs[rf_sel[1:0]] <= rf_wdata;
      end
    end
  end

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    int                lat;
  } exp_t;

  exp_t exp_q [$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a command and return just after its accept edge.
  task automatic issue(input logic [1:0] op, input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] data);
    int n;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_data  = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_timeout", 32'(n < 50), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] d, input logic e, input int lat);
    exp_q.push_back('{data: d, err: e, lat: lat});
  endtask

  // Called just after the accept edge: measures latency and scores the response.
  task automatic await_rsp(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_lat"},  32'(lat),      32'(e.lat));
      chk({tag, "_data"}, 32'(rsp_data), 32'(e.data));
      chk({tag, "_err"},  32'(rsp_err),  32'(e.err));
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [SEL_W-1:0] sel,
                         input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] ed,
                         input logic ee, input int lat);
    push_exp(ed, ee, lat);
    issue(op, sel, data);
    await_rsp(tag);
    handshake();
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) regs[r] = '0;
    force_b0  = 1'b0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_sel   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_rf_enable", 32'(rf_enable), 32'd0);
    chk("rst_rf_sel",    32'(rf_sel),    32'd0);
    chk("rst_rf_wdata",  32'(rf_wdata),  32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    reset = 1'b0;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write then read back.
    run_cmd("wr_a5", 2'b01, 4'd2, 8'hA5, 8'hA5, 1'b0, 2);
    rf_log.delete();
    run_cmd("rd_a5", 2'b00, 4'd2, 8'h00, 8'hA5, 1'b0, 2);
    chk("rd_cycles",   32'(rf_log.size()), 32'd1);
    if (rf_log.size() == 1) begin
      chk("rd_sel",     32'(rf_log[0].sel),   32'd2);
      chk("rd_refresh", 32'(rf_log[0].wdata), 32'hA5);
    end

    // Write-verify against a register file with a stuck bit 0.
    force_b0 = 1'b1;
    rf_log.delete();
    run_cmd("wv", 2'b10, 4'd1, 8'h3C, 8'h3D, 1'b1, 3);
    force_b0 = 1'b0;
    chk("wv_cycles", 32'(rf_log.size()), 32'd2);
    if (rf_log.size() == 2) begin
      chk("wv_wr_data", 32'(rf_log[0].wdata), 32'h3C);
      chk("wv_rd_sel",  32'(rf_log[1].sel),   32'd1);
    end

    // Fill then clear with zero-check scan.
    for (int r = 0; r < NREGS; r++) run_cmd("fill", 2'b01, SEL_W'(r), 8'hFF, 8'hFF, 1'b0, 2);
    rf_log.delete();
    run_cmd("clr", 2'b11, 4'd9, 8'h00, 8'h00, 1'b0, NREGS + 2);
    chk("clr_cycles", 32'(rf_log.size()), 32'(NREGS + 1));
    if (rf_log.size() == NREGS + 1) begin
      chk("clr_reset_first", 32'(rf_log[0].rst), 32'd1);
      for (int r = 0; r < NREGS; r++) begin
        chk("scan_sel",   32'(rf_log[r+1].sel), 32'(r));
        chk("scan_noreset", 32'(rf_log[r+1].rst), 32'd0);
      end
    end

    // Clear that finds a stuck bit reports an error.
    force_b0 = 1'b1;
    run_cmd("clr_bad", 2'b11, 4'd0, 8'h00, 8'h01, 1'b1, NREGS + 2);
    force_b0 = 1'b0;

    // Illegal select.
    rf_log.delete();
    run_cmd("ill", 2'b00, 4'd7, 8'h00, 8'h00, 1'b1, 1);
    chk("ill_no_rf", 32'(rf_log.size()), 32'd0);

    // Back-pressure: response held, next command waits for the handshake.
    push_exp(8'h5A, 1'b0, 2);
    issue(2'b01, 4'd3, 8'h5A);
    cmd_op = 2'b00; cmd_sel = 4'd3; cmd_data = 8'h00; cmd_valid = 1'b1;
    await_rsp("bp_wr");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data",  32'(rsp_data),  32'h5A);
      chk("bp_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("bp_not_same_edge", 32'(busy), 32'd0);
    push_exp(8'h5A, 1'b0, 2);
    tick();
    cmd_valid = 1'b0;
    chk("bp_accepted_next", 32'(busy), 32'd1);
    await_rsp("bp_rd");
    handshake();

    // Reset during the scan at idx 2.
    issue(2'b11, 4'd0, 8'h00);
    tick();
    tick();
    tick();
    chk("mid_scan_sel", 32'(rf_sel), 32'd2);
    rf_log.delete();
    reset = 1'b1;
    #1;
    chk("mid_rst_rf_enable", 32'(rf_enable), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    tick();
    tick();
    chk("mid_rst_no_rf", 32'(rf_log.size()), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rel_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rel_no_rsp", 32'(rsp_valid), 32'd0);
    run_cmd("post_rst_wr", 2'b01, 4'd0, 8'hC3, 8'hC3, 1'b0, 2);
    run_cmd("post_rst_rd", 2'b00, 4'd0, 8'h00, 8'hC3, 1'b0, 2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
